cmd_executor: RTL

//  Downstream of the 3-bit command decoder in the simple processor. Consumes the 8-bit command code and executes it.

---
 rtl/proc_cmd_pkg.sv | 30 +++
 rtl/wdt_counter.sv | 35 +++
 rtl/cmd_executor.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/proc_cmd_pkg.sv
// rtl/proc_cmd_pkg.sv - command codes and executor state encoding shared with the decoder side
package proc_cmd_pkg;

   // Command codes produced by the 3-bit decoder, widened to a byte
   typedef enum logic [7:0] {
      CMD_RST    = 8'h00,
      CMD_WD_WR  = 8'h01,
      CMD_WD_RD  = 8'h02,
      CMD_RAM_WR = 8'h03,
      CMD_MEM_WR = 8'h04,
      CMD_MEM_RD = 8'h05,
      CMD_RSV6   = 8'h06,
      CMD_RSV7   = 8'h07
   } cmd_e;

   // Executor control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      BUS  = 2'd2
   } exec_state_e;

   localparam logic [7:0] CMD_LAST_LEGAL = 8'h07;

   // True for the three commands that go out on the memory bus
   function automatic logic is_bus_cmd(input logic [7:0] code);
      return (code == CMD_RAM_WR) || (code == CMD_MEM_WR) || (code == CMD_MEM_RD);
   endfunction

endpackage

// File: rtl/wdt_counter.sv
// rtl/wdt_counter.sv - loadable down-counting watchdog with single-cycle expiry pulse
module wdt_counter
   import proc_cmd_pkg::*;
#(
   parameter int WDT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_clear,
   input  logic [WDT_W-1:0] i_load_val,
   output logic [WDT_W-1:0] o_count,
   output logic             o_expire
);

   logic [WDT_W-1:0] r_count;

   // Clear and load take precedence over the free-running decrement; zero means disarmed
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - WDT_W'(1);
      end
   end

   // Expiry fires on the edge that takes the count from 1 to 0, unless overridden
   assign o_expire = (r_count == WDT_W'(1)) && !i_load && !i_clear;
   assign o_count  = r_count;

endmodule

// File: rtl/cmd_executor.sv
// rtl/cmd_executor.sv - executes decoded commands locally or over a req/ack memory bus (option: CMD_EXEC_TIMEOUT_EN)
module cmd_executor
   import proc_cmd_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int WDT_W       = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        cmd_code,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic              mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              wdt_expired,
   output logic              err
);

   exec_state_e       r_state;
   logic              r_cmd_ready;
   logic              r_mem_req;
   logic              r_mem_we;
   logic              r_mem_sel;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;
   logic              r_wdt_expired;
   logic              r_err;

   logic              w_accept;
   logic              w_wdt_load;
   logic              w_wdt_clear;
   logic              w_wdt_expire;
   logic [WDT_W-1:0]  w_wdt_count;

`ifdef CMD_EXEC_TIMEOUT_EN
   // Wait counter is at least a byte wide and always wide enough to reach TIMEOUT_CYC
   localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [TW-1:0]     r_wait_cnt;
   logic              w_timeout;
   assign w_timeout = (r_wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
   logic              w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYC;
`endif

   // Accept only while idle; cmd_ready is a registered mirror of the IDLE state
   assign w_accept    = cmd_valid && r_cmd_ready;
   assign w_wdt_clear = w_accept && (cmd_code == CMD_RST);
   assign w_wdt_load  = w_accept && (cmd_code == CMD_WD_WR);

   wdt_counter #(
      .WDT_W (WDT_W)
   ) u_wdt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_wdt_load),
      .i_clear    (w_wdt_clear),
      .i_load_val (wr_data[WDT_W-1:0]),
      .o_count    (w_wdt_count),
      .o_expire   (w_wdt_expire)
   );

   // Command FSM with registered bus, status and read-result outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_cmd_ready   <= 1'b1;
         r_mem_req     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_sel     <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_rd_data     <= '0;
         r_rd_valid    <= 1'b0;
         r_wdt_expired <= 1'b0;
         r_err         <= 1'b0;
`ifdef CMD_EXEC_TIMEOUT_EN
         r_wait_cnt    <= '0;
`endif
      end else begin
         r_rd_valid <= 1'b0;
         if (w_wdt_expire) begin
            r_wdt_expired <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_mem_addr  <= cmd_addr;
                  r_mem_wdata <= wr_data;
                  r_cmd_ready <= 1'b0;
                  if (is_bus_cmd(cmd_code)) begin
                     r_mem_req <= 1'b1;
                     r_mem_we  <= (cmd_code != CMD_MEM_RD);
                     r_mem_sel <= (cmd_code != CMD_RAM_WR);
                     r_state   <= BUS;
`ifdef CMD_EXEC_TIMEOUT_EN
                     r_wait_cnt <= '0;
`endif
                  end else begin
                     r_state <= EXEC;
                     case (cmd_code)
                        CMD_RST: begin
                           r_wdt_expired <= 1'b0;
                           r_err         <= 1'b0;
                           r_rd_data     <= '0;
                        end
                        CMD_WD_WR: begin
                           r_wdt_expired <= 1'b0;
                        end
                        CMD_WD_RD: begin
                           r_rd_data  <= DATA_W'(w_wdt_count);
                           r_rd_valid <= 1'b1;
                        end
                        default: begin
                           r_err <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            EXEC: begin
               r_state     <= IDLE;
               r_cmd_ready <= 1'b1;
            end
            BUS: begin
               if (mem_ack) begin
                  r_mem_req   <= 1'b0;
                  r_state     <= IDLE;
                  r_cmd_ready <= 1'b1;
                  if (!r_mem_we) begin
                     r_rd_data  <= mem_rdata;
                     r_rd_valid <= 1'b1;
                  end
`ifdef CMD_EXEC_TIMEOUT_EN
               end else if (w_timeout) begin
                  r_mem_req   <= 1'b0;
                  r_err       <= 1'b1;
                  r_state     <= IDLE;
                  r_cmd_ready <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + TW'(1);
`endif
               end
            end
            default: begin
               r_state     <= IDLE;
               r_cmd_ready <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_sel     = r_mem_sel;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign rd_data     = r_rd_data;
   assign rd_valid    = r_rd_valid;
   assign wdt_expired = r_wdt_expired;
   assign err         = r_err;

endmodule
